// File: rtl/ysyx_25050147_mem_arbiter.sv
// Two-master round-robin arbiter for the shared data memory port.
// One transaction in flight; stalled slave times out with an error response.
module ysyx_25050147_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MASK_W  = 8,
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_addr,
  output logic              ifu_rsp_valid,
  input  logic              ifu_rsp_ready,
  output logic [DATA_W-1:0] ifu_rdata,
  output logic              ifu_rsp_err,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic              lsu_wen,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [MASK_W-1:0] lsu_wmask,
  output logic              lsu_rsp_valid,
  input  logic              lsu_rsp_ready,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic              lsu_rsp_err,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [MASK_W-1:0] mem_wmask,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } state_t;

  localparam bit TMO_EN = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  state_t state_q, state_d;

  logic              owner_q;
  logic              last_q;
  logic [ADDR_W-1:0] addr_q;
  logic              wen_q;
  logic [DATA_W-1:0] wdata_q;
  logic [MASK_W-1:0] wmask_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic [CNT_W-1:0]  cnt_q;

  logic pick_ifu;
  logic pick_lsu;
  logic tmo;

  // Round-robin pick: on a tie the master not granted last time wins
  always_comb begin
    pick_ifu = ifu_req_valid & (~lsu_req_valid | last_q);
    pick_lsu = lsu_req_valid & (~ifu_req_valid | ~last_q);
    tmo      = TMO_EN & (cnt_q == CNT_MAX);
  end

  // Next state and all handshake/data outputs, silenced during reset
  always_comb begin
    state_d       = state_q;
    ifu_req_ready = 1'b0;
    lsu_req_ready = 1'b0;
    ifu_rsp_valid = 1'b0;
    ifu_rdata     = '0;
    ifu_rsp_err   = 1'b0;
    lsu_rsp_valid = 1'b0;
    lsu_rdata     = '0;
    lsu_rsp_err   = 1'b0;
    mem_req_valid = 1'b0;
    mem_addr      = '0;
    mem_wen       = 1'b0;
    mem_wdata     = '0;
    mem_wmask     = '0;
    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          ifu_req_ready = pick_ifu;
          lsu_req_ready = pick_lsu;
          if (pick_ifu | pick_lsu) state_d = REQ;
        end
        REQ: begin
          mem_req_valid = 1'b1;
          mem_addr      = addr_q;
          mem_wen       = wen_q;
          mem_wdata     = wdata_q;
          mem_wmask     = wmask_q;
          if (mem_req_ready) state_d = WAIT;
        end
        WAIT: begin
          if (mem_rsp_valid | tmo) state_d = RESP;
        end
        RESP: begin
          if (owner_q) begin
            lsu_rsp_valid = 1'b1;
            lsu_rdata     = rdata_q;
            lsu_rsp_err   = err_q;
            if (lsu_rsp_ready) state_d = IDLE;
          end else begin
            ifu_rsp_valid = 1'b1;
            ifu_rdata     = rdata_q;
            ifu_rsp_err   = err_q;
            if (ifu_rsp_ready) state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, request latch, timeout counter and response capture
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (pick_ifu | pick_lsu) begin
            owner_q <= pick_lsu;
            last_q  <= pick_lsu;
            addr_q  <= pick_lsu ? lsu_addr : ifu_addr;
            wen_q   <= pick_lsu & lsu_wen;
            wdata_q <= pick_lsu ? lsu_wdata : '0;
            wmask_q <= pick_lsu ? lsu_wmask : '0;
          end
        end
        REQ: begin
          if (mem_req_ready) cnt_q <= '0;
        end
        WAIT: begin
          if (mem_rsp_valid) begin
            rdata_q <= mem_rdata;
            err_q   <= 1'b0;
          end else if (tmo) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25050147_mem_arbiter.sv
// Bench for the memory arbiter: memory responder, scoreboard of
// expected responses popped on each master response handshake.
module tb_ysyx_25050147_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready;
  logic [31:0] ifu_addr;
  logic        ifu_rsp_valid, ifu_rsp_ready;
  logic [31:0] ifu_rdata;
  logic        ifu_rsp_err;
  logic        lsu_req_valid, lsu_req_ready;
  logic [31:0] lsu_addr;
  logic        lsu_wen;
  logic [31:0] lsu_wdata;
  logic [7:0]  lsu_wmask;
  logic        lsu_rsp_valid, lsu_rsp_ready;
  logic [31:0] lsu_rdata;
  logic        lsu_rsp_err;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_rsp_valid;
  logic [31:0] mem_rdata;

  typedef struct {
    bit          m;
    logic [31:0] d;
    bit          e;
  } exp_t;

  exp_t sb[$];
  bit   grants[$];
  bit   wens[$];

  int n_chk  = 0;
  int n_fail = 0;
  int n_rsp  = 0;

  bit          mute = 0;
  bit          inject = 0;
  logic [31:0] inj_data = 32'h0;
  int          stall_left = 0;
  bit          hs, hw;
  logic [31:0] ha;

  ysyx_25050147_mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MASK_W(8),
    .TIMEOUT(4), .CNT_W(9)
  ) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
    .ifu_addr(ifu_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready),
    .ifu_rdata(ifu_rdata), .ifu_rsp_err(ifu_rsp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
    .lsu_addr(lsu_addr), .lsu_wen(lsu_wen),
    .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready),
    .lsu_rdata(lsu_rdata), .lsu_rsp_err(lsu_rsp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_wen(mem_wen),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return (a == 32'h8000_0000) ? 32'h0010_0073 : (a ^ 32'h5A5A_A5A5);
  endfunction

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic take(input bit m, input logic [31:0] d, input bit e);
    exp_t x;
    n_rsp++;
    chk("sb_pending", 64'(sb.size() != 0), 1);
    if (sb.size() != 0) begin
      x = sb.pop_front();
      chk("rsp_owner", 64'(m), 64'(x.m));
      chk("rsp_rdata", d, x.d);
      chk("rsp_err", 64'(e), 64'(x.e));
    end
  endtask

  task automatic push(input bit m, input logic [31:0] d, input bit e);
    exp_t x;
    x.m = m;
    x.d = d;
    x.e = e;
    sb.push_back(x);
  endtask

  task automatic send(input bit m, input logic [31:0] a, input bit w,
                      input logic [31:0] wd, input logic [7:0] wm);
    int n = 0;
    if (m) begin
      lsu_req_valid = 1'b1;
      lsu_addr = a;
      lsu_wen = w;
      lsu_wdata = wd;
      lsu_wmask = wm;
    end else begin
      ifu_req_valid = 1'b1;
      ifu_addr = a;
    end
    #1;
    while (!(m ? lsu_req_ready : ifu_req_ready) && n < 50) begin
      tick();
      n++;
    end
    chk("req_accept", 64'(n < 50), 1);
    tick();
    if (m) lsu_req_valid = 1'b0;
    else ifu_req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    chk("drain", 64'(sb.size()), 0);
    tick();
  endtask

  // Response scoreboard and handshake logging, sampled mid-cycle
  always @(negedge clk) begin
    if (!rst) begin
      chk("rsp_excl", 64'(ifu_rsp_valid & lsu_rsp_valid), 0);
      if (ifu_rsp_valid && ifu_rsp_ready) take(0, ifu_rdata, ifu_rsp_err);
      if (lsu_rsp_valid && lsu_rsp_ready) take(1, lsu_rdata, lsu_rsp_err);
      if (ifu_req_valid && ifu_req_ready) grants.push_back(1'b0);
      if (lsu_req_valid && lsu_req_ready) grants.push_back(1'b1);
      if (mem_req_valid && mem_req_ready) wens.push_back(mem_wen);
    end
  end

  // Memory model: answers one cycle after accept unless muted
  initial begin
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      hs = !rst && mem_req_valid && mem_req_ready;
      ha = mem_addr;
      hw = mem_wen;
      @(posedge clk);
      #1;
      mem_rsp_valid = 1'b0;
      mem_rdata = $urandom;
      if (inject) begin
        mem_rsp_valid = 1'b1;
        mem_rdata = inj_data;
        inject = 1'b0;
      end else if (hs && !mute) begin
        mem_rsp_valid = 1'b1;
        mem_rdata = hw ? 32'h0 : mdata(ha);
      end
      if (mem_req_valid && stall_left > 0) begin
        mem_req_ready = 1'b0;
        stall_left--;
      end else begin
        mem_req_ready = 1'b1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int saved;
    rst = 1'b1;
    ifu_req_valid = 1'b1;
    lsu_req_valid = 1'b1;
    ifu_addr = 32'h0;
    lsu_addr = 32'h0;
    lsu_wen = 1'b0;
    lsu_wdata = 32'h0;
    lsu_wmask = 8'h0;
    ifu_rsp_ready = 1'b1;
    lsu_rsp_ready = 1'b1;
    tick();
    tick();
    chk("rst_ifu_rdy", 64'(ifu_req_ready), 0);
    chk("rst_lsu_rdy", 64'(lsu_req_ready), 0);
    chk("rst_mem_v", 64'(mem_req_valid), 0);
    chk("rst_mem_a", mem_addr, 0);
    chk("rst_ifu_rv", 64'(ifu_rsp_valid), 0);
    chk("rst_lsu_rv", 64'(lsu_rsp_valid), 0);
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    rst = 1'b0;
    tick();
    chk("post_mem_v", 64'(mem_req_valid), 0);
    chk("post_mem_a", mem_addr, 0);
    chk("post_ifu_d", ifu_rdata, 0);
    chk("post_lsu_d", lsu_rdata, 0);

    // Single IFU read, minimum latency
    ifu_req_valid = 1'b1;
    ifu_addr = 32'h8000_0000;
    #1;
    chk("t1_ifu_rdy", 64'(ifu_req_ready), 1);
    chk("t1_lsu_rdy", 64'(lsu_req_ready), 0);
    push(0, 32'h0010_0073, 0);
    tick();
    ifu_req_valid = 1'b0;
    chk("t1_mem_v", 64'(mem_req_valid), 1);
    chk("t1_mem_a", mem_addr, 32'h8000_0000);
    chk("t1_mem_wen", 64'(mem_wen), 0);
    chk("t1_mem_wd", mem_wdata, 0);
    chk("t1_mem_wm", 64'(mem_wmask), 0);
    tick();
    chk("t1_rv_c2", 64'(ifu_rsp_valid), 0);
    tick();
    chk("t1_rv_c3", 64'(ifu_rsp_valid), 1);
    chk("t1_rdata", ifu_rdata, 32'h0010_0073);
    chk("t1_err", 64'(ifu_rsp_err), 0);
    chk("t1_lsu_rv", 64'(lsu_rsp_valid), 0);
    drain();

    // LSU write with a 4-cycle request stall
    stall_left = 4;
    push(1, 32'h0, 0);
    send(1, 32'h8000_1000, 1, 32'hDEAD_BEEF, 8'h0F);
    for (int i = 0; i < 4; i++) begin
      chk("t3_mem_v", 64'(mem_req_valid), 1);
      chk("t3_mem_a", mem_addr, 32'h8000_1000);
      chk("t3_mem_wen", 64'(mem_wen), 1);
      chk("t3_mem_wd", mem_wdata, 32'hDEAD_BEEF);
      chk("t3_mem_wm", 64'(mem_wmask), 8'h0F);
      tick();
    end
    drain();

    // Both masters requesting continuously
    grants.delete();
    wens.delete();
    ifu_addr = 32'h8000_0040;
    lsu_addr = 32'h8000_2000;
    lsu_wen = 1'b1;
    lsu_wdata = 32'h1122_3344;
    lsu_wmask = 8'hFF;
    for (int i = 0; i < 2; i++) begin
      push(0, mdata(32'h8000_0040), 0);
      push(1, 32'h0, 0);
    end
    ifu_req_valid = 1'b1;
    lsu_req_valid = 1'b1;
    n = 0;
    while (grants.size() < 4 && n < 100) begin
      tick();
      n++;
    end
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    drain();
    chk("t2_ngrant", 64'(grants.size()), 4);
    chk("t2_nwen", 64'(wens.size()), 4);
    for (int i = 0; i < 4; i++) begin
      chk("t2_grant", 64'(grants[i]), 64'(i % 2));
      chk("t2_wen", 64'(wens[i]), 64'(i % 2));
    end
    lsu_wen = 1'b0;

    // Timeout after exactly 4 WAIT cycles
    mute = 1'b1;
    push(0, 32'h0, 1);
    send(0, 32'h8000_0300, 0, 32'h0, 8'h0);
    tick();
    n = 0;
    while (!ifu_rsp_valid && n < 20) begin
      tick();
      n++;
    end
    chk("t4_tmo_lat", 64'(n), 4);
    chk("t4_err", 64'(ifu_rsp_err), 1);
    chk("t4_rdata", ifu_rdata, 0);
    drain();
    saved = n_rsp;
    @(negedge clk);
    inj_data = 32'h7777_7777;
    inject = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("t4_late_rsp", 64'(n_rsp), 64'(saved));
    chk("t4_late_rv", 64'(ifu_rsp_valid), 0);

    // Response arrives on the last WAIT cycle: data wins
    push(0, 32'hCAFE_F00D, 0);
    send(0, 32'h8000_0400, 0, 32'h0, 8'h0);
    tick();
    tick();
    tick();
    @(negedge clk);
    inj_data = 32'hCAFE_F00D;
    inject = 1'b1;
    drain();
    mute = 1'b0;

    // Response backpressure with a competing IFU request
    lsu_rsp_ready = 1'b0;
    push(1, mdata(32'h8000_3000), 0);
    send(1, 32'h8000_3000, 0, 32'h0, 8'h0);
    n = 0;
    while (!lsu_rsp_valid && n < 20) begin
      tick();
      n++;
    end
    ifu_req_valid = 1'b1;
    ifu_addr = 32'h8000_0200;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t5_rv", 64'(lsu_rsp_valid), 1);
      chk("t5_rdata", lsu_rdata, mdata(32'h8000_3000));
      chk("t5_ifu_rdy", 64'(ifu_req_ready), 0);
    end
    lsu_rsp_ready = 1'b1;
    push(0, mdata(32'h8000_0200), 0);
    tick();
    #1;
    chk("t5_ifu_acc", 64'(ifu_req_ready), 1);
    tick();
    ifu_req_valid = 1'b0;
    drain();

    // Reset while an IFU read is waiting
    mute = 1'b1;
    send(0, 32'h8000_0500, 0, 32'h0, 8'h0);
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("t6_rst_memv", 64'(mem_req_valid), 0);
    chk("t6_rst_rv", 64'(ifu_rsp_valid), 0);
    tick();
    rst = 1'b0;
    mute = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("t6_ifu_rv", 64'(ifu_rsp_valid), 0);
      chk("t6_memv", 64'(mem_req_valid), 0);
      tick();
    end
    ifu_req_valid = 1'b1;
    lsu_req_valid = 1'b1;
    ifu_addr = 32'h8000_0600;
    lsu_addr = 32'h8000_4000;
    lsu_wen = 1'b0;
    #1;
    chk("t6_ifu_first", 64'(ifu_req_ready), 1);
    chk("t6_lsu_wait", 64'(lsu_req_ready), 0);
    push(0, mdata(32'h8000_0600), 0);
    push(1, mdata(32'h8000_4000), 0);
    tick();
    ifu_req_valid = 1'b0;
    send(1, 32'h8000_4000, 0, 32'h0, 8'h0);
    drain();

    chk("sb_empty", 64'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
